// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32 decode (ALU, M-subset, LUI, CSRRW) with a
// valid/ready handshake and a one-entry skid buffer for full-rate backpressure.
module rv_decode_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [31:0]      out_imm,
    output logic [3:0]       out_aluop,
    output logic             out_src_imm,
    output logic             out_regwrite,
    output logic             out_csr_we,
    output logic [11:0]      out_csr_addr,
    output logic             out_illegal,
    output logic [CNT_W-1:0] decode_count
);
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND   = 4'd2,  ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,  ALU_SLL  = 4'd5,  ALU_SRL   = 4'd6,  ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,  ALU_SLTU = 4'd9,  ALU_MUL   = 4'd10, ALU_MULH  = 4'd11,
        ALU_MULHU = 4'd12, ALU_LUI  = 4'd13, ALU_CSRRW = 4'd14
    } aluop_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  aluop;
        logic        src_imm;
        logic        regwrite;
        logic        csr_we;
        logic [11:0] csr_addr;
        logic        illegal;
    } bundle_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_legal;
    aluop_e     w_op;
    bundle_t    w_dec;
    logic       w_accept;
    logic       w_handoff;

    bundle_t          r_out;
    logic             r_out_valid;
    bundle_t          r_skid;
    logic             r_skid_valid;
    logic [CNT_W-1:0] r_count;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];

    always_comb begin
        w_legal        = 1'b1;
        w_op           = ALU_ADD;
        w_dec          = '0;
        w_dec.rd       = in_instr[11:7];
        w_dec.rs1      = in_instr[19:15];
        w_dec.rs2      = in_instr[24:20];
        case (w_opcode)
            OP_R: begin
                case ({w_funct7, w_funct3})
                    10'b0000000_000: w_op = ALU_ADD;
                    10'b0100000_000: w_op = ALU_SUB;
                    10'b0000000_111: w_op = ALU_AND;
                    10'b0000000_110: w_op = ALU_OR;
                    10'b0000000_100: w_op = ALU_XOR;
                    10'b0000000_001: w_op = ALU_SLL;
                    10'b0000000_101: w_op = ALU_SRL;
                    10'b0100000_101: w_op = ALU_SRA;
                    10'b0000000_010: w_op = ALU_SLT;
                    10'b0000000_011: w_op = ALU_SLTU;
                    10'b0000001_000: w_op = ALU_MUL;
                    10'b0000001_001: w_op = ALU_MULH;
                    10'b0000001_011: w_op = ALU_MULHU;
                    default:         w_legal = 1'b0;
                endcase
            end
            OP_I: begin
                w_dec.src_imm = 1'b1;
                w_dec.imm     = {{20{in_instr[31]}}, in_instr[31:20]};
                case (w_funct3)
                    3'b000: w_op = ALU_ADD;
                    3'b111: w_op = ALU_AND;
                    3'b110: w_op = ALU_OR;
                    3'b100: w_op = ALU_XOR;
                    3'b001: begin
                        w_dec.imm = {27'b0, in_instr[24:20]};
                        if (w_funct7 == 7'b0000000) w_op = ALU_SLL;
                        else                        w_legal = 1'b0;
                    end
                    3'b101: begin
                        w_dec.imm = {27'b0, in_instr[24:20]};
                        if (w_funct7 == 7'b0000000)      w_op = ALU_SRL;
                        else if (w_funct7 == 7'b0100000) w_op = ALU_SRA;
                        else                             w_legal = 1'b0;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OP_LUI: begin
                w_dec.src_imm = 1'b1;
                w_dec.imm     = {in_instr[31:12], 12'b0};
                w_op          = ALU_LUI;
            end
            OP_SYS: begin
                if (w_funct3 == 3'b001) begin
                    w_dec.csr_we   = 1'b1;
                    w_dec.csr_addr = in_instr[31:20];
                    w_op           = ALU_CSRRW;
                end else begin
                    w_legal = 1'b0;
                end
            end
            default: w_legal = 1'b0;
        endcase
        // Illegal words still travel down the pipe but must have no side effects.
        if (!w_legal) begin
            w_dec.imm      = '0;
            w_dec.src_imm  = 1'b0;
            w_dec.csr_we   = 1'b0;
            w_dec.csr_addr = '0;
            w_op           = ALU_ADD;
        end
        w_dec.aluop    = w_op;
        w_dec.illegal  = ~w_legal;
        w_dec.regwrite = w_legal && (w_dec.rd != 5'd0);
    end

    assign in_ready  = ~r_skid_valid;
    assign w_accept  = in_valid && in_ready;
    assign w_handoff = r_out_valid && out_ready;

    // The skid register only fills when a word arrives while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_valid <= 1'b0;
        end else if (w_handoff) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out <= w_dec;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (r_out_valid) begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end else begin
                r_out       <= w_dec;
                r_out_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_accept && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid    = r_out_valid;
    assign out_rd       = r_out.rd;
    assign out_rs1      = r_out.rs1;
    assign out_rs2      = r_out.rs2;
    assign out_imm      = r_out.imm;
    assign out_aluop    = r_out.aluop;
    assign out_src_imm  = r_out.src_imm;
    assign out_regwrite = r_out.regwrite;
    assign out_csr_we   = r_out.csr_we;
    assign out_csr_addr = r_out.csr_addr;
    assign out_illegal  = r_out.illegal;
    assign decode_count = r_count;
endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Pipelined decode stage for the RV32 core: accepts 32-bit instruction words from fetch and emits decoded control/operand fields to execute.
- Covers the subset the core supports: R-type ALU (ADD SUB AND OR XOR SLL SRL SRA SLT SLTU), M-subset (MUL MULH MULHU), I-type ALU (ADDI ANDI ORI XORI SLLI SRLI SRAI), LUI, and CSRRW.
- Uses a valid/ready handshake on both sides, with a one-entry skid buffer so full throughput holds under backpressure.

Parameters:
- CNT_W, 16, width of the saturating decoded-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  instruction word.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts the bundle.
- out_rd  out  5  destination register.
- out_rs1  out  5  source register 1.
- out_rs2  out  5  source register 2.
- out_imm  out  32  decoded immediate.
- out_aluop  out  4  ALU operation code.
- out_src_imm  out  1  ALU operand B is out_imm, not rs2.
- out_regwrite  out  1  write rd.
- out_csr_we  out  1  CSR write (CSRRW).
- out_csr_addr  out  12  CSR address.
- out_illegal  out  1  unsupported encoding.
- decode_count  out  CNT_W  accepted instructions, saturating.

Behaviour:
- Reset (async, immediate on rst=1):
  - out_valid=0 and skid buffer empty, so in_ready=1 once rst deasserts.
  - decode_count=0.
  - All out_* data fields = 0.
  - Reset mid-transfer discards both the output-register and skid-register contents.
- Accept and hand-off:
  - Accept occurs when in_valid&&in_ready. The decode is registered, so a bundle appears on out_* the cycle after accept (latency 1).
  - Hand-off occurs when out_valid&&out_ready.
- Skid buffer:
  - in_ready = skid empty, and is a registered signal.
  - If an accept happens while out_valid=1 and out_ready=0, the decoded word goes to the skid register and in_ready drops next cycle.
  - On the next hand-off, skid moves to the output register and in_ready rises.
  - Simultaneous accept and hand-off with skid empty: the new word loads directly into the output register.
- Ordering: strict FIFO order. No instruction is dropped or duplicated.
- Output hold: out_* stay stable while out_valid=1 and out_ready=0.
- aluop codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, MUL=10, MULH=11, MULHU=12, LUI=13, CSRRW=14.
- Field extraction (all formats): rd=[11:7], rs1=[19:15], rs2=[24:20].
- Opcode 0110011 (R-type):
  - Decode on funct7/funct3: 0000000/000 ADD, 0100000/000 SUB, 0000000/111 AND, /110 OR, /100 XOR, /001 SLL, /101 SRL, 0100000/101 SRA, 0000000/010 SLT, /011 SLTU, 0000001/000 MUL, /001 MULH, /011 MULHU.
  - src_imm=0, imm=0.
- Opcode 0010011 (I-type):
  - funct3 000 ADDI, 111 ANDI, 110 ORI, 100 XORI, with imm=sign-extended [31:20].
  - SLLI is funct3 001 with [31:25]=0000000.
  - SRLI is funct3 101 with [31:25]=0000000; SRAI is funct3 101 with [31:25]=0100000.
  - For shifts, imm={27'b0,[24:20]}.
  - src_imm=1.
- Opcode 0110111 (LUI): imm={[31:20... actually [31:12],12'b0}, aluop=LUI, src_imm=1.
- Opcode 1110011 with funct3 001 (CSRRW): csr_addr=[31:20], csr_we=1, aluop=CSRRW, imm=0.
- Illegal encoding (any other opcode/funct combination): illegal=1, regwrite=0, csr_we=0, aluop=ADD, imm=0. The bundle is still delivered.
- regwrite: 1 for every legal instruction, except forced to 0 when rd=0.
- csr_we: CSRRW with rd=0 keeps csr_we=1.
- Counter: decode_count increments by 1 on each accept, including illegal instructions. It saturates at all-ones and never wraps.

Test Plan:
- Reset then in_instr=0x002081B3 (ADD x3,x1,x2) with out_ready=1 -> next cycle out_valid=1, rd=3, rs1=1, rs2=2, aluop=0, src_imm=0, regwrite=1, decode_count=1.
- Back-to-back 0x402081B3 (SUB), 0x022081B3 (MUL), 0x0220B1B3 (MULHU), out_ready=1 -> aluops 1, 10, 12 on consecutive cycles, in_ready constant 1.
- 0xFFF08193 (ADDI x3,x1,-1) -> imm=0xFFFFFFFF, src_imm=1. 0x4040D193 (SRAI x3,x1,4) -> aluop=7, imm=4. 0x0000F1B7 (LUI x3,0xF) -> imm=0x0000F000, aluop=13.
- 0x0C0091F3 (CSRRW x3,0x0C0,x1) -> csr_we=1, csr_addr=0x0C0, aluop=14. 0x0C00F1F3 (funct3 111) -> illegal=1, regwrite=0, csr_we=0.
- Hold out_ready=0, push 3 words -> 2 accepted, in_ready=0 from cycle after 2nd accept, out_* stable. Release out_ready -> all 3 delivered in order, none lost.
- CNT_W=2, issue 5 instructions -> decode_count 1,2,3,3,3. Assert rst while skid full -> out_valid=0, in_ready=1, count=0 immediately.
